// File: rtl/index_decoder_reg_if.sv
// index_decoder_reg_if
//   Command/response bundle for index_decoder_reg.
//   slave  : seen by the decoder (commands in, vector and one-hot out)
//   master : seen by the command source / consumer
//   Signals:
//     in_valid/in_ready  command handshake
//     in_idx, in_op      binary index and operation (0=SET 1=CLR 2=TOGGLE 3=LOAD)
//     clr_all            synchronous clear of the whole vector
//     vec, vec_count     registered request vector and its popcount
//     oh_valid/oh_ready  one-hot output handshake, oh = one-hot of last index
//     err                one-cycle pulse when an accepted index is out of range
interface index_decoder_reg_if #(
    parameter int OUT_WIDTH = 32
);
    localparam int IDX_WIDTH = $clog2(OUT_WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [IDX_WIDTH-1:0] in_idx;
    logic [1:0]           in_op;
    logic                 clr_all;
    logic [OUT_WIDTH-1:0] vec;
    logic [IDX_WIDTH:0]   vec_count;
    logic                 oh_valid;
    logic                 oh_ready;
    logic [OUT_WIDTH-1:0] oh;
    logic                 err;

    modport slave (
        input  in_valid, in_idx, in_op, clr_all, oh_ready,
        output in_ready, vec, vec_count, oh_valid, oh, err
    );

    modport master (
        output in_valid, in_idx, in_op, clr_all, oh_ready,
        input  in_ready, vec, vec_count, oh_valid, oh, err
    );
endinterface

// File: rtl/index_decoder_reg.sv
// index_decoder_reg
//   Registered binary-index-to-vector decoder: write side of the request
//   bitmap consumed by the priority encoders. Each accepted command updates
//   a persistent OUT_WIDTH-bit vector and emits a one-hot of its index
//   through a single-entry valid/ready output stage.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    index_decoder_reg_if.slave (see interface for signal list)
module index_decoder_reg #(
    parameter int OUT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    index_decoder_reg_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(OUT_WIDTH);
    // One extra bit so the range compare stays meaningful for power-of-two widths.
    localparam logic [IDX_WIDTH:0]   IDX_LIMIT = (IDX_WIDTH + 1)'(OUT_WIDTH);
    localparam logic [OUT_WIDTH-1:0] ONE       = OUT_WIDTH'(1);

    localparam logic [1:0] OP_SET  = 2'd0;
    localparam logic [1:0] OP_CLR  = 2'd1;
    localparam logic [1:0] OP_TOG  = 2'd2;

    logic [OUT_WIDTH-1:0] r_vec;
    logic [OUT_WIDTH-1:0] r_oh;
    logic [IDX_WIDTH:0]   r_count;
    logic                 r_oh_valid;
    logic                 r_err;

    logic [OUT_WIDTH-1:0] w_vec_nxt;
    logic [OUT_WIDTH-1:0] w_onehot;
    logic [IDX_WIDTH:0]   w_count_nxt;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_in_range;

    assign w_in_ready = !r_oh_valid || bus.oh_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_in_range = {1'b0, bus.in_idx} < IDX_LIMIT;
    assign w_onehot   = w_in_range ? (ONE << bus.in_idx) : '0;

    // clr_all overrides any vector effect of a same-cycle command.
    always_comb begin
        w_vec_nxt = r_vec;
        if (bus.clr_all) begin
            w_vec_nxt = '0;
        end else if (w_accept && w_in_range) begin
            case (bus.in_op)
                OP_SET:  w_vec_nxt = r_vec | w_onehot;
                OP_CLR:  w_vec_nxt = r_vec & ~w_onehot;
                OP_TOG:  w_vec_nxt = r_vec ^ w_onehot;
                default: w_vec_nxt = w_onehot;
            endcase
        end
    end

    // Popcount of the next vector so vec_count lands on the same edge as vec.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_count_nxt = w_count_nxt + (IDX_WIDTH + 1)'(w_vec_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= '0;
            r_count    <= '0;
            r_oh       <= '0;
            r_oh_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_vec   <= w_vec_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_accept && !w_in_range;
            if (w_accept) begin
                r_oh       <= w_onehot;
                r_oh_valid <= 1'b1;
            end else if (bus.oh_ready) begin
                r_oh_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.vec       = r_vec;
    assign bus.vec_count = r_count;
    assign bus.oh        = r_oh;
    assign bus.oh_valid  = r_oh_valid;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_index_decoder_reg.sv
// tb_index_decoder_reg
//   Directed bench for index_decoder_reg at OUT_WIDTH=32 and OUT_WIDTH=20.
//   Stimulus pushes the hand-computed response of each command into a queue;
//   a monitor per instance pops and compares on the cycle after each accept.
module tb_index_decoder_reg;
    localparam logic [1:0] OP_SET  = 2'd0;
    localparam logic [1:0] OP_CLR  = 2'd1;
    localparam logic [1:0] OP_TOG  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    typedef struct {
        logic [31:0] oh;
        logic [31:0] vec;
        int          cnt;
        bit          err;
    } exp_t;

    logic clk;
    logic rst_n;

    index_decoder_reg_if #(.OUT_WIDTH(32)) b32 ();
    index_decoder_reg_if #(.OUT_WIDTH(20)) b20 ();

    index_decoder_reg #(.OUT_WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    index_decoder_reg #(.OUT_WIDTH(20)) u_dut20 (.clk(clk), .rst_n(rst_n), .bus(b20));

    exp_t q32[$];
    exp_t q20[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic ohv,
                             input logic [31:0] oh, input logic [31:0] vec,
                             input int cnt, input logic err);
        check({tag, " oh_valid"},  64'(ohv), 64'(1));
        check({tag, " oh"},        64'(oh),  64'(e.oh));
        check({tag, " vec"},       64'(vec), 64'(e.vec));
        check({tag, " vec_count"}, 64'(cnt), 64'(e.cnt));
        check({tag, " err"},       64'(err), 64'(e.err));
    endtask

    // Monitors: an accept seen at the negedge before an edge means a response
    // is due at the following negedge.
    initial begin
        bit   acc_prev;
        exp_t e;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_prev) begin
                if (q32.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL w32 unexpected output: oh=0x%0h, expected none", b32.oh);
                end else begin
                    e = q32.pop_front();
                    check_out("w32", e, b32.oh_valid, b32.oh, b32.vec, int'(b32.vec_count), b32.err);
                end
            end
            acc_prev = rst_n && b32.in_valid && b32.in_ready;
        end
    end

    initial begin
        bit   acc_prev;
        exp_t e;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (acc_prev) begin
                if (q20.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL w20 unexpected output: oh=0x%0h, expected none", b20.oh);
                end else begin
                    e = q20.pop_front();
                    check_out("w20", e, b20.oh_valid, 32'(b20.oh), 32'(b20.vec), int'(b20.vec_count), b20.err);
                end
            end
            acc_prev = rst_n && b20.in_valid && b20.in_ready;
        end
    end

    task automatic drive(input bit w20, input int idx, input logic [1:0] op, input bit clr,
                         input logic [31:0] ev, input int ec, input logic [31:0] eoh, input bit eerr);
        exp_t e;
        e.oh  = eoh;
        e.vec = ev;
        e.cnt = ec;
        e.err = eerr;
        if (w20) begin
            b20.in_valid = 1'b1;
            b20.in_idx   = 5'(idx);
            b20.in_op    = op;
            b20.clr_all  = clr;
            q20.push_back(e);
        end else begin
            b32.in_valid = 1'b1;
            b32.in_idx   = 5'(idx);
            b32.in_op    = op;
            b32.clr_all  = clr;
            q32.push_back(e);
        end
    endtask

    // Returns #1 after the accepting edge, command still driven.
    task automatic wait_acc(input bit w20);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = w20 ? (b20.in_valid && b20.in_ready) : (b32.in_valid && b32.in_ready);
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s accept timeout: got no accept, expected accept within 20 cycles", w20 ? "w20" : "w32");
        end
    endtask

    task automatic send(input bit w20, input int idx, input logic [1:0] op, input bit clr,
                        input logic [31:0] ev, input int ec, input logic [31:0] eoh, input bit eerr);
        drive(w20, idx, op, clr, ev, ec, eoh, eerr);
        wait_acc(w20);
    endtask

    task automatic idle();
        b32.in_valid = 1'b0;
        b32.clr_all  = 1'b0;
        b20.in_valid = 1'b0;
        b20.clr_all  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b1;
        b32.in_valid = 1'b0;
        b32.in_idx   = '0;
        b32.in_op    = OP_SET;
        b32.clr_all  = 1'b0;
        b32.oh_ready = 1'b1;
        b20.in_valid = 1'b0;
        b20.in_idx   = '0;
        b20.in_op    = OP_SET;
        b20.clr_all  = 1'b0;
        b20.oh_ready = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        check("reset vec",       64'(b32.vec),       64'(0));
        check("reset vec_count", 64'(b32.vec_count), 64'(0));
        check("reset oh",        64'(b32.oh),        64'(0));
        check("reset oh_valid",  64'(b32.oh_valid),  64'(0));
        check("reset err",       64'(b32.err),       64'(0));
        check("reset in_ready",  64'(b32.in_ready),  64'(1));
        check("reset w20 vec",   64'(b20.vec),       64'(0));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ops
        send(0, 5,  OP_SET,  0, 32'h0000_0020, 1, 32'h0000_0020, 0);
        send(0, 31, OP_SET,  0, 32'h8000_0020, 2, 32'h8000_0000, 0);
        send(0, 5,  OP_TOG,  0, 32'h8000_0000, 1, 32'h0000_0020, 0);
        send(0, 0,  OP_LOAD, 0, 32'h0000_0001, 1, 32'h0000_0001, 0);
        send(0, 0,  OP_SET,  0, 32'h0000_0001, 1, 32'h0000_0001, 0);
        send(0, 0,  OP_CLR,  0, 32'h0000_0000, 0, 32'h0000_0001, 0);
        send(0, 0,  OP_CLR,  0, 32'h0000_0000, 0, 32'h0000_0001, 0);
        idle();
        check("oh_valid drops after handshake", 64'(b32.oh_valid), 64'(0));

        // Backpressure
        b32.oh_ready = 1'b0;
        send(0, 3, OP_SET, 0, 32'h0000_0008, 1, 32'h0000_0008, 0);
        b32.in_valid = 1'b0;
        check("bp in_ready low", 64'(b32.in_ready), 64'(0));
        check("bp oh_valid",     64'(b32.oh_valid), 64'(1));
        drive(0, 4, OP_SET, 0, 32'h0000_0018, 2, 32'h0000_0010, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp hold in_ready", 64'(b32.in_ready), 64'(0));
            check("bp hold vec",      64'(b32.vec),      64'(32'h8));
            check("bp hold oh",       64'(b32.oh),       64'(32'h8));
            @(posedge clk);
            #1;
        end
        b32.oh_ready = 1'b1;
        wait_acc(0);

        // Build 0xFF, then clr_all together with SET 9
        send(0, 0, OP_LOAD, 0, 32'h0000_0001, 1, 32'h0000_0001, 0);
        send(0, 1, OP_SET,  0, 32'h0000_0003, 2, 32'h0000_0002, 0);
        send(0, 2, OP_SET,  0, 32'h0000_0007, 3, 32'h0000_0004, 0);
        send(0, 3, OP_SET,  0, 32'h0000_000F, 4, 32'h0000_0008, 0);
        send(0, 4, OP_SET,  0, 32'h0000_001F, 5, 32'h0000_0010, 0);
        send(0, 5, OP_SET,  0, 32'h0000_003F, 6, 32'h0000_0020, 0);
        send(0, 6, OP_SET,  0, 32'h0000_007F, 7, 32'h0000_0040, 0);
        send(0, 7, OP_SET,  0, 32'h0000_00FF, 8, 32'h0000_0080, 0);
        send(0, 9, OP_SET,  1, 32'h0000_0000, 0, 32'h0000_0200, 0);
        idle();

        // Full vector, streamed one per cycle
        for (int i = 0; i < 32; i++) begin
            send(0, i, OP_SET, 0, 32'((64'd1 << (i + 1)) - 64'd1), i + 1, 32'(64'd1 << i), 0);
        end
        for (int i = 0; i < 32; i++) begin
            send(0, i, OP_CLR, 0, ~32'((64'd1 << (i + 1)) - 64'd1), 31 - i, 32'(64'd1 << i), 0);
        end
        idle();
        check("full clear vec_count", 64'(b32.vec_count), 64'(0));

        // Out of range on the 20-bit instance
        send(1, 19, OP_SET,  0, 32'h0008_0000, 1, 32'h0008_0000, 0);
        send(1, 25, OP_SET,  0, 32'h0008_0000, 1, 32'h0000_0000, 1);
        idle();
        check("w20 err one cycle", 64'(b20.err),      64'(0));
        check("w20 oh_valid idle", 64'(b20.oh_valid), 64'(0));
        send(1, 31, OP_LOAD, 0, 32'h0008_0000, 1, 32'h0000_0000, 1);
        idle();
        check("w20 vec after bad load", 64'(b20.vec), 64'(32'h0008_0000));

        // Asynchronous reset with a pending output
        b32.oh_ready = 1'b0;
        send(0, 3, OP_SET, 0, 32'h0000_0008, 1, 32'h0000_0008, 0);
        b32.in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async rst vec",       64'(b32.vec),       64'(0));
        check("async rst vec_count", 64'(b32.vec_count), 64'(0));
        check("async rst oh",        64'(b32.oh),        64'(0));
        check("async rst oh_valid",  64'(b32.oh_valid),  64'(0));
        check("async rst in_ready",  64'(b32.in_ready),  64'(1));
        check("async rst w20 vec",   64'(b20.vec),       64'(0));
        #1 rst_n = 1'b1;
        b32.oh_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post rst in_ready", 64'(b32.in_ready), 64'(1));
        send(0, 7, OP_SET, 0, 32'h0000_0080, 1, 32'h0000_0080, 0);
        idle();
        idle();

        check("w32 queue drained", 64'(q32.size()), 64'(0));
        check("w20 queue drained", 64'(q20.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
